// File: rtl/debounce_scan_ctrl.sv
// Shared scanned debouncer: one prescaled sample tick, one button visited per
// cycle, press/release pulses and a small event queue. Define
// DEBOUNCE_SCAN_RELEASE_EVT_EN to queue release events alongside presses.
module debounce_scan_ctrl #(
  parameter int N_BTN      = 4,
  parameter int PRESCALE   = 50000,
  parameter int STABLE_CNT = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_BTN-1:0] button_i,
  input  logic             event_ack_i,
  output logic             sample_tick_o,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic             event_valid_o,
  output logic [IDW-1:0]   event_id_o,
  output logic             event_rel_o,
  output logic             overflow_o,
  output logic             dbg_state_o
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW   = 4;
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int CNTW = FAW + 1;
`ifdef DEBOUNCE_SCAN_RELEASE_EVT_EN
  localparam bit REL_EVT = 1'b1;
  localparam int EW      = IDW + 1;
`else
  localparam bit REL_EVT = 1'b0;
  localparam int EW      = IDW;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic             visit;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q, rel_d;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [FAW-1:0]   head_q, tail_q;
  logic [CNTW-1:0]  count_q;
  logic             overflow_q;

  logic             s_bit, cur_lvl, flip;
  logic [CW-1:0]    cur_cnt, cnt_nxt;
  logic             full, pop, push_req, push_ok;

  // Prescaler: tick_q is high for the cycle after the count reaches PRESCALE-1.
  always_comb begin
    presc_d = presc_q + 1'b1;
    tick_d  = 1'b0;
    if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A tick seen during SCAN is ignored; PRESCALE >= N_BTN+2 keeps it unreachable.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDW'(N_BTN - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    visit       = (state_q == ST_SCAN);
    dbg_state_o = (state_q == ST_SCAN);
  end

  // One visit per cycle: compare the synchronized sample with the debounced level.
  always_comb begin
    s_bit   = sync2_q[idx_q];
    cur_lvl = level_q[idx_q];
    cur_cnt = cnt_q[idx_q];
    flip    = 1'b0;
    cnt_nxt = '0;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    if (visit && (s_bit != cur_lvl)) begin
      if (cur_cnt == CW'(STABLE_CNT - 1)) begin
        flip           = 1'b1;
        level_d[idx_q] = s_bit;
        press_d[idx_q] = s_bit;
        rel_d[idx_q]   = ~s_bit;
      end else begin
        cnt_nxt = cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      if (visit) cnt_q[idx_q] <= cnt_nxt;
    end
  end

  // Handshake: the head is offered while event_valid_o is high and is consumed on
  // any cycle with event_valid_o && event_ack_i; ack with an empty queue does nothing.
  assign full     = (count_q == CNTW'(FIFO_DEPTH));
  assign pop      = (count_q != '0) && event_ack_i;
  assign push_req = flip && (s_bit || REL_EVT);
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
`ifdef DEBOUNCE_SCAN_RELEASE_EVT_EN
        mem_q[tail_q] <= {~s_bit, idx_q};
`else
        mem_q[tail_q] <= idx_q;
`endif
        tail_q <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign sample_tick_o = tick_q;
  assign level_o       = level_q;
  assign press_o       = press_q;
  assign release_o     = rel_q;
  assign event_valid_o = (count_q != '0);
  assign event_id_o    = mem_q[head_q][IDW-1:0];
  assign overflow_o    = overflow_q;
`ifdef DEBOUNCE_SCAN_RELEASE_EVT_EN
  assign event_rel_o   = mem_q[head_q][IDW];
`else
  assign event_rel_o   = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios with literal expectations plus
// randomized buttons/acks checked every cycle against a tick/visit-schedule model.
module tb_debounce_scan_ctrl;

  localparam int NB  = 4;
  localparam int PRE = 8;
  localparam int STB = 3;
  localparam int DEP = 4;
`ifdef DEBOUNCE_SCAN_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_drv = 1'b1;
  logic          ack_drv = 1'b0;
  logic [NB-1:0] button_drv = '0;

  logic          sample_tick_o, event_valid_o, event_rel_o, overflow_o, dbg_state_o;
  logic [NB-1:0] level_o, press_o, release_o;
  logic [1:0]    event_id_o;

  debounce_scan_ctrl #(
    .N_BTN(NB), .PRESCALE(PRE), .STABLE_CNT(STB), .FIFO_DEPTH(DEP)
  ) dut (
    .clk_i(clk), .reset_i(reset_drv), .button_i(button_drv), .event_ack_i(ack_drv),
    .sample_tick_o(sample_tick_o), .level_o(level_o), .press_o(press_o),
    .release_o(release_o), .event_valid_o(event_valid_o), .event_id_o(event_id_o),
    .event_rel_o(event_rel_o), .overflow_o(overflow_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int            n_vec = 0;
  int            n_miss = 0;
  int            k = 0;
  bit            chk_en = 1'b0;
  logic [NB-1:0] b_hist [4096];
  logic [NB-1:0] m_level, exp_press, exp_rel;
  logic          exp_tick, m_ovf;
  int            m_run [NB];
  logic [2:0]    exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, k);
    end
  endtask

  task automatic model_reset();
    m_level   = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_tick  = 1'b0;
    m_ovf     = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) m_run[i] = 0;
  endtask

  // Button i is sampled in cycle 8m+1+i (m>=1), seeing the raw value from 2 cycles before.
  function automatic bit visit_outcome(input int kk, output int i, output logic s, output bit flip);
    i = 0;
    s = 1'b0;
    flip = 1'b0;
    if (kk < PRE + 1 || (kk % PRE) < 1 || (kk % PRE) > NB) return 1'b0;
    i = (kk % PRE) - 1;
    s = b_hist[(kk - 2) % 4096][i];
    flip = (s != m_level[i]) && (m_run[i] == STB - 1);
    return 1'b1;
  endfunction

  // Advance the model across the edge that ends cycle k.
  task automatic model_edge();
    int   vi;
    logic vs;
    bit   vf;
    b_hist[k % 4096] = button_drv;
    exp_tick  = ((k + 1) % PRE == 0);
    exp_press = '0;
    exp_rel   = '0;
    if (exp_q.size() != 0 && ack_drv) void'(exp_q.pop_front());
    if (visit_outcome(k, vi, vs, vf)) begin
      if (vs == m_level[vi]) begin
        m_run[vi] = 0;
      end else if (!vf) begin
        m_run[vi]++;
      end else begin
        m_run[vi]   = 0;
        m_level[vi] = vs;
        if (vs) exp_press[vi] = 1'b1;
        else    exp_rel[vi]   = 1'b1;
        if (vs || REL_EN) begin
          if (exp_q.size() < DEP) exp_q.push_back({~vs, 2'(vi)});
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sample_tick", sample_tick_o, exp_tick);
      chk("level", level_o, m_level);
      chk("press", press_o, exp_press);
      chk("release", release_o, exp_rel);
      chk("event_valid", event_valid_o, exp_q.size() != 0);
      chk("overflow", overflow_o, m_ovf);
      if (exp_q.size() != 0) begin
        chk("event_id", event_id_o, exp_q[0][1:0]);
        chk("event_rel", event_rel_o, exp_q[0][2]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    k++;
  endtask

  task automatic do_reset();
    chk_en     = 1'b0;
    reset_drv  = 1'b1;
    button_drv = '0;
    ack_drv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_drv = 1'b0;
    model_reset();
    k = 0;
    chk_en = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NB; i++)
      if ($urandom_range(0, 19) == 0) button_drv[i] = ~button_drv[i];
    ack_drv = ($urandom_range(0, 3) == 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_tick, second_tick, first_press, press_cnt, rel_cnt, pops, stage;
    int vi;
    logic vs;
    bit vf, done;
    logic [1:0] popped[$];

    // Reset release and tick cadence.
    do_reset();
    first_tick  = -1;
    second_tick = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (sample_tick_o && first_tick < 0) first_tick = k;
      else if (sample_tick_o && second_tick < 0) second_tick = k;
    end
    chk("first_tick_cycle", first_tick, 8);
    chk("second_tick_cycle", second_tick, 16);

    // button[2] held from cycle 0: press after the third agreeing visit (cycle 27).
    do_reset();
    button_drv  = 4'b0100;
    first_press = -1;
    press_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (press_o[2]) begin
        press_cnt++;
        if (first_press < 0) first_press = k;
      end
    end
    chk("btn2_press_cycle", first_press, 28);
    chk("btn2_press_width", press_cnt, 1);
    chk("btn2_level", level_o, 4'b0100);
    chk("btn2_queue_valid", event_valid_o, 1);
    chk("btn2_queue_id", event_id_o, 2);

    // Glitch: button[1] seen 1,1,0 across three ticks then 0.
    do_reset();
    button_drv = 4'b0010;
    press_cnt  = 0;
    while (k < 24) begin step(); if (press_o[1]) press_cnt++; end
    button_drv = 4'b0000;
    while (k < 60) begin step(); if (press_o[1]) press_cnt++; end
    chk("glitch_level", level_o[1], 0);
    chk("glitch_press_cnt", press_cnt, 0);
    chk("glitch_queue_empty", event_valid_o, 0);

    // Overflow: four presses fill the queue, a fifth press of button 0 is dropped.
    do_reset();
    button_drv = 4'hF;
    while (k < 32) step();
    button_drv = 4'hE;
    while (k < 60) step();
    button_drv = 4'hF;
    while (k < 90) step();
    chk("ovf_sticky", overflow_o, 1);
    chk("ovf_queue_valid", event_valid_o, 1);
    ack_drv = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (event_valid_o) popped.push_back(event_id_o);
      step();
    end
    ack_drv = 1'b0;
    chk("ovf_pop_count", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("ovf_pop_order", (i < popped.size()) ? popped[i] : 2'bxx, i);
    chk("ovf_drained", event_valid_o, 0);

    // Full queue with ack in the same cycle as a new push: nothing dropped.
    do_reset();
    button_drv = 4'hF;
    stage = 0;
    done  = 1'b0;
    while (!done && k < 400) begin
      if (stage == 0 && exp_q.size() == DEP) stage = 1;
      if (stage == 1 && m_level[0] == 1'b0) stage = 2;
      button_drv = (stage == 1) ? 4'hE : 4'hF;
      if (visit_outcome(k, vi, vs, vf) && vf && (vs || REL_EN) && exp_q.size() == DEP) begin
        ack_drv = 1'b1;
        done    = 1'b1;
      end
      step();
      ack_drv = 1'b0;
    end
    chk("full_ack_coincide", done, 1);
    repeat (30) step();
    chk("full_ack_no_ovf", overflow_o, 0);
    ack_drv = 1'b1;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      if (event_valid_o) pops++;
      step();
    end
    ack_drv = 1'b0;
    chk("full_ack_occupancy", pops, 4);

    // Press then release button[3].
    do_reset();
    button_drv = 4'h8;
    while (!event_valid_o && k < 60) step();
    chk("b3_press_valid", event_valid_o, 1);
    chk("b3_press_id", event_id_o, 3);
    chk("b3_press_rel", event_rel_o, 0);
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    button_drv = 4'h0;
    rel_cnt = 0;
    repeat (40) begin step(); if (release_o[3]) rel_cnt++; end
    chk("b3_release_pulse", rel_cnt, 1);
`ifdef DEBOUNCE_SCAN_RELEASE_EVT_EN
    chk("b3_rel_valid", event_valid_o, 1);
    chk("b3_rel_id", event_id_o, 3);
    chk("b3_rel_flag", event_rel_o, 1);
`else
    chk("b3_rel_not_queued", event_valid_o, 0);
`endif

    // Randomized run with a reset in the middle of a scan.
    do_reset();
    for (int c = 0; c < 700; c++) begin rand_inputs(); step(); end
    while (k % PRE != 2) begin rand_inputs(); step(); end
    chk("mid_scan_busy", dbg_state_o, 1);
    do_reset();
    chk("post_reset_level", level_o, 0);
    chk("post_reset_scan", dbg_state_o, 0);
    for (int c = 0; c < 800; c++) begin rand_inputs(); step(); end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
